// File: rtl/id_ex_pipe_reg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : id_ex_pipe_reg
// Brief    : ID/EX pipeline register with load/hold/flush control decoded from
//            the hazard stall vector, plus saturating hold/flush event counters.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module id_ex_pipe_reg #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [7:0]       i_stall,
   input  logic [XLEN-1:0]  i_pc,
   input  logic [XLEN-1:0]  i_rs1data,
   input  logic [XLEN-1:0]  i_rs2data,
   input  logic [XLEN-1:0]  i_imm,
   input  logic [4:0]       i_rs1addr,
   input  logic [4:0]       i_rs2addr,
   input  logic [4:0]       i_rdaddr,
   input  logic             i_rdwren,
   input  logic [1:0]       i_wbsel,
   input  logic             i_memwren,
   input  logic [3:0]       i_aluop,
   input  logic             i_brsel,
   input  logic             i_valid,
   input  logic             i_cnt_clr,
   output logic [XLEN-1:0]  o_pc,
   output logic [XLEN-1:0]  o_rs1data,
   output logic [XLEN-1:0]  o_rs2data,
   output logic [XLEN-1:0]  o_imm,
   output logic [4:0]       o_rs1addr,
   output logic [4:0]       o_rs2addr,
   output logic [4:0]       o_rdaddr,
   output logic             o_rdwren,
   output logic [1:0]       o_wbsel,
   output logic             o_memwren,
   output logic [3:0]       o_aluop,
   output logic             o_brsel,
   output logic             o_valid,
   output logic [CNT_W-1:0] o_hold_cnt,
   output logic [CNT_W-1:0] o_flush_cnt
);

   localparam logic [1:0]       c_LOAD    = 2'b00;
   localparam logic [1:0]       c_FLUSH   = 2'b11;
   localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [XLEN-1:0]  r_pc;
   logic [XLEN-1:0]  r_rs1data;
   logic [XLEN-1:0]  r_rs2data;
   logic [XLEN-1:0]  r_imm;
   logic [4:0]       r_rs1addr;
   logic [4:0]       r_rs2addr;
   logic [4:0]       r_rdaddr;
   logic             r_rdwren;
   logic [1:0]       r_wbsel;
   logic             r_memwren;
   logic [3:0]       r_aluop;
   logic             r_brsel;
   logic             r_valid;
   logic [CNT_W-1:0] r_hold_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic [1:0] w_code;
   logic       w_load;
   logic       w_flush;
   logic       w_hold;
   logic       w_unused_stall;

   assign w_code         = i_stall[4:3];
   assign w_load         = (w_code == c_LOAD);
   assign w_flush        = (w_code == c_FLUSH);
   // The reserved code 2'b10 behaves exactly like HOLD.
   assign w_hold         = ~w_load & ~w_flush;
   assign w_unused_stall = ^{i_stall[7:5], i_stall[2:0]};

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst || (!i_rst && w_flush)) begin
         r_pc      <= '0;
         r_rs1data <= '0;
         r_rs2data <= '0;
         r_imm     <= '0;
         r_rs1addr <= '0;
         r_rs2addr <= '0;
         r_rdaddr  <= '0;
         r_rdwren  <= 1'b0;
         r_wbsel   <= 2'b00;
         r_memwren <= 1'b0;
         r_aluop   <= '0;
         r_brsel   <= 1'b0;
         r_valid   <= 1'b0;
      end else if (w_load) begin
         r_pc      <= i_pc;
         r_rs1data <= i_rs1data;
         r_rs2data <= i_rs2data;
         r_imm     <= i_imm;
         r_rs1addr <= i_rs1addr;
         r_rs2addr <= i_rs2addr;
         r_rdaddr  <= i_rdaddr;
         // Side-effecting enables are squashed for a non-valid instruction.
         r_rdwren  <= i_rdwren  & i_valid;
         r_wbsel   <= i_wbsel;
         r_memwren <= i_memwren & i_valid;
         r_aluop   <= i_aluop;
         r_brsel   <= i_brsel   & i_valid;
         r_valid   <= i_valid;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_hold_cnt  <= '0;
         r_flush_cnt <= '0;
      end else if (i_cnt_clr) begin
         r_hold_cnt  <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_hold && !(&r_hold_cnt)) begin
            r_hold_cnt <= r_hold_cnt + c_CNT_ONE;
         end
         // Only flushes that actually kill a live instruction are counted.
         if (w_flush && r_valid && !(&r_flush_cnt)) begin
            r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
         end
      end
   end

   assign o_pc        = r_pc;
   assign o_rs1data   = r_rs1data;
   assign o_rs2data   = r_rs2data;
   assign o_imm       = r_imm;
   assign o_rs1addr   = r_rs1addr;
   assign o_rs2addr   = r_rs2addr;
   assign o_rdaddr    = r_rdaddr;
   assign o_rdwren    = r_rdwren;
   assign o_wbsel     = r_wbsel;
   assign o_memwren   = r_memwren;
   assign o_aluop     = r_aluop;
   assign o_brsel     = r_brsel;
   assign o_valid     = r_valid;
   assign o_hold_cnt  = r_hold_cnt;
   assign o_flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe_reg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_id_ex_pipe_reg
// Brief    : Randomized self-checking bench for id_ex_pipe_reg against a
//            behavioural model of the EX-stage contents and event counters.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_id_ex_pipe_reg;

   localparam int XLEN    = 32;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst;
   logic [7:0]       i_stall;
   logic [XLEN-1:0]  i_pc, i_rs1data, i_rs2data, i_imm;
   logic [4:0]       i_rs1addr, i_rs2addr, i_rdaddr;
   logic             i_rdwren, i_memwren, i_brsel, i_valid, i_cnt_clr;
   logic [1:0]       i_wbsel;
   logic [3:0]       i_aluop;
   logic [XLEN-1:0]  o_pc, o_rs1data, o_rs2data, o_imm;
   logic [4:0]       o_rs1addr, o_rs2addr, o_rdaddr;
   logic             o_rdwren, o_memwren, o_brsel, o_valid;
   logic [1:0]       o_wbsel;
   logic [3:0]       o_aluop;
   logic [CNT_W-1:0] o_hold_cnt, o_flush_cnt;

   id_ex_pipe_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_stall(i_stall),
      .i_pc(i_pc), .i_rs1data(i_rs1data), .i_rs2data(i_rs2data), .i_imm(i_imm),
      .i_rs1addr(i_rs1addr), .i_rs2addr(i_rs2addr), .i_rdaddr(i_rdaddr),
      .i_rdwren(i_rdwren), .i_wbsel(i_wbsel), .i_memwren(i_memwren),
      .i_aluop(i_aluop), .i_brsel(i_brsel), .i_valid(i_valid), .i_cnt_clr(i_cnt_clr),
      .o_pc(o_pc), .o_rs1data(o_rs1data), .o_rs2data(o_rs2data), .o_imm(o_imm),
      .o_rs1addr(o_rs1addr), .o_rs2addr(o_rs2addr), .o_rdaddr(o_rdaddr),
      .o_rdwren(o_rdwren), .o_wbsel(o_wbsel), .o_memwren(o_memwren),
      .o_aluop(o_aluop), .o_brsel(o_brsel), .o_valid(o_valid),
      .o_hold_cnt(o_hold_cnt), .o_flush_cnt(o_flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc, rs1data, rs2data, imm;
      logic [4:0]  rs1addr, rs2addr, rdaddr;
      logic        rdwren;
      logic [1:0]  wbsel;
      logic        memwren;
      logic [3:0]  aluop;
      logic        brsel, valid;
   } ex_t;

   ex_t m_ex;
   int  m_hold;
   int  m_flush;
   int  n_cmp;
   int  n_bad;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      check_val({tag, ".pc"},      o_pc,              m_ex.pc);
      check_val({tag, ".rs1data"}, o_rs1data,         m_ex.rs1data);
      check_val({tag, ".rs2data"}, o_rs2data,         m_ex.rs2data);
      check_val({tag, ".imm"},     o_imm,             m_ex.imm);
      check_val({tag, ".rs1addr"}, 32'(o_rs1addr),    32'(m_ex.rs1addr));
      check_val({tag, ".rs2addr"}, 32'(o_rs2addr),    32'(m_ex.rs2addr));
      check_val({tag, ".rdaddr"},  32'(o_rdaddr),     32'(m_ex.rdaddr));
      check_val({tag, ".ctrl"},    32'({o_rdwren, o_wbsel, o_memwren, o_aluop, o_brsel, o_valid}),
                32'({m_ex.rdwren, m_ex.wbsel, m_ex.memwren, m_ex.aluop, m_ex.brsel, m_ex.valid}));
      check_val({tag, ".hold_cnt"},  32'(o_hold_cnt),  32'(m_hold));
      check_val({tag, ".flush_cnt"}, 32'(o_flush_cnt), 32'(m_flush));
   endtask

   // Drive a new ID-stage instruction with random fields.
   task automatic drive(input logic [7:0] st, input logic clr);
      i_stall   = st;
      i_cnt_clr = clr;
      i_pc      = $urandom;
      i_rs1data = $urandom;
      i_rs2data = $urandom;
      i_imm     = $urandom;
      i_rs1addr = 5'($urandom);
      i_rs2addr = 5'($urandom);
      i_rdaddr  = 5'($urandom);
      i_rdwren  = 1'($urandom);
      i_wbsel   = 2'($urandom);
      i_memwren = 1'($urandom);
      i_aluop   = 4'($urandom);
      i_brsel   = 1'($urandom);
      i_valid   = 1'($urandom);
   endtask

   function automatic int sat_inc(input int v);
      return (v >= CNT_MAX) ? CNT_MAX : v + 1;
   endfunction

   // Apply one rising edge to the model, then compare just after it.
   task automatic tick(input string tag);
      @(posedge clk);
      case (i_stall[4:3])
         2'b00: begin
            m_ex = '{pc: i_pc, rs1data: i_rs1data, rs2data: i_rs2data, imm: i_imm,
                     rs1addr: i_rs1addr, rs2addr: i_rs2addr, rdaddr: i_rdaddr,
                     rdwren: i_rdwren && i_valid, wbsel: i_wbsel,
                     memwren: i_memwren && i_valid, aluop: i_aluop,
                     brsel: i_brsel && i_valid, valid: i_valid};
         end
         2'b11: begin
            if (m_ex.valid) m_flush = sat_inc(m_flush);
            m_ex = '0;
         end
         default: m_hold = sat_inc(m_hold);
      endcase
      if (i_cnt_clr) begin
         m_hold  = 0;
         m_flush = 0;
      end
      #1;
      check_all(tag);
   endtask

   task automatic model_reset();
      m_ex    = '0;
      m_hold  = 0;
      m_flush = 0;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      model_reset();

      // Reset with random inputs toggling
      rst = 1'b1;
      drive(8'($urandom), 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         drive(8'($urandom), 1'($urandom));
      end
      #1;
      check_all("reset");
      check_val("reset.valid", 32'(o_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // LOAD
      drive(8'h00, 1'b0);
      i_pc = 32'h100; i_rdaddr = 5'd5; i_rdwren = 1'b1; i_valid = 1'b1;
      tick("load");
      check_val("load.pc", o_pc, 32'h100);
      check_val("load.rdaddr", 32'(o_rdaddr), 32'd5);
      check_val("load.rdwren", 32'(o_rdwren), 32'd1);
      check_val("load.valid", 32'(o_valid), 32'd1);

      // Load-use hold: outputs must not follow the new inputs
      drive(8'b1_01_01_11_0, 1'b0);
      tick("hold");
      check_val("hold.pc", o_pc, 32'h100);
      check_val("hold.cnt", 32'(o_hold_cnt), 32'd1);

      // Branch flush of a valid instruction, then of the bubble
      drive(8'b0_11_11_11_0, 1'b0);
      tick("flush1");
      check_val("flush1.valid", 32'(o_valid), 32'd0);
      check_val("flush1.rdwren", 32'(o_rdwren), 32'd0);
      check_val("flush1.memwren", 32'(o_memwren), 32'd0);
      check_val("flush1.cnt", 32'(o_flush_cnt), 32'd1);
      drive(8'b0_11_11_11_0, 1'b0);
      tick("flush2");
      check_val("flush2.cnt", 32'(o_flush_cnt), 32'd1);

      // Saturation over 20 holds (reserved code mixed in), then clear beats increment
      for (int i = 0; i < 20; i++) begin
         drive({3'($urandom), (i % 2 == 0) ? 2'b01 : 2'b10, 3'($urandom)}, 1'b0);
         tick("sat");
      end
      check_val("sat.hold_cnt", 32'(o_hold_cnt), 32'd15);
      drive(8'b0000_1000, 1'b1);
      tick("clr");
      check_val("clr.hold_cnt", 32'(o_hold_cnt), 32'd0);

      // Asynchronous reset between edges during a HOLD
      drive(8'h00, 1'b0);
      i_valid = 1'b1;
      tick("preload");
      drive(8'b0000_1000, 1'b0);
      tick("prehold");
      #3 rst = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      drive(8'h00, 1'b0);
      #2 rst = 1'b0;
      tick("post_rst_load");

      // Randomized traffic with occasional counter clears
      for (int i = 0; i < 400; i++) begin
         drive(8'($urandom), ($urandom_range(0, 19) == 0));
         tick("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
